// File: rtl/dmem_ext_pipe_pkg.sv
// Shared constants, encodings and the load-response entry type for dmem_ext_pipe.
package dmem_pkg;

  // Default geometry of the data memory.
  localparam int DMEM_SIZE       = 1024;
  localparam int DMEM_ADDR_WIDTH = 10;
  localparam int DMEM_COL_WIDTH  = 8;
  localparam int DMEM_NB_COL     = 4;
  localparam int DMEM_TAG_WIDTH  = 4;
  localparam int DMEM_RSP_DEPTH  = 2;

  // Word width.
  localparam int DMEM_W = DMEM_NB_COL * DMEM_COL_WIDTH;

  // Encoding of req_st.
  localparam logic REQ_LOAD  = 1'b0;
  localparam logic REQ_STORE = 1'b1;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // One load response as it travels through S1 and the response FIFO.
  typedef struct packed {
    logic [DMEM_W-1:0]         data;
    logic [DMEM_TAG_WIDTH-1:0] tag;
    logic                      err;
  } rsp_entry_t;

endpackage

// File: rtl/dmem_ext_pipe_if.sv
// Request/response channel between the core memory stage and dmem_ext_pipe.
interface dmem_ext_pipe_if
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int COL_WIDTH  = DMEM_COL_WIDTH,
  parameter int NB_COL     = DMEM_NB_COL,
  parameter int TAG_WIDTH  = DMEM_TAG_WIDTH
);
  localparam int W = NB_COL * COL_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_st;
  logic [NB_COL-1:0]     req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [W-1:0]          req_wdata;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [W-1:0]          rsp_rdata;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  rsp_err;

  // Core side: issues requests, consumes responses.
  modport master (
    output req_valid, req_st, req_we, req_addr, req_wdata, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_tag, rsp_err
  );

  // Memory side.
  modport slave (
    input  req_valid, req_st, req_we, req_addr, req_wdata, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_tag, rsp_err
  );

endinterface

// File: rtl/dmem_rsp_fifo.sv
// First-word-fall-through response FIFO: circular buffer with wrapping
// read/write pointers and an occupancy count.
module dmem_rsp_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Entry storage write.
  // NOTE: storage is deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= enq_data;
  end

  // Pointer and occupancy update; simultaneous enq/deq keeps the count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Occupancy is bounded upstream by the credit counter; these firing is a bug.
  a_no_overflow:  assert property (@(posedge clk) disable iff (!reset_n) !(enq && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(deq && empty));

endmodule

// File: rtl/dmem_ext_pipe.sv
// Byte-lane-writable data memory with synchronous read, credit-limited load
// acceptance, a registered S1 stage and an in-order tagged response FIFO.
// Response entry widths follow the dmem_pkg word and tag widths.
module dmem_ext_pipe
  import dmem_pkg::*;
#(
  parameter int SIZE       = DMEM_SIZE,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int COL_WIDTH  = DMEM_COL_WIDTH,
  parameter int NB_COL     = DMEM_NB_COL,
  parameter int TAG_WIDTH  = DMEM_TAG_WIDTH,
  parameter int RSP_DEPTH  = DMEM_RSP_DEPTH
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_ext_pipe_if.slave bus
);
  localparam int W       = NB_COL * COL_WIDTH;
  localparam int CNT_W   = cnt_width(RSP_DEPTH);
  localparam int ENTRY_W = $bits(rsp_entry_t);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RSP_DEPTH);

  logic [CNT_W-1:0]     out_cnt;
  logic                 req_fire;
  logic                 ld_fire;
  logic                 st_fire;
  logic                 in_range;
  logic                 s1_valid;
  logic [W-1:0]         s1_data;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic                 s1_err;
  rsp_entry_t           s1_entry;
  rsp_entry_t           head_entry;
  rsp_entry_t           out_entry;
  logic [ENTRY_W-1:0]   fifo_head;
  logic                 fifo_enq;
  logic                 fifo_deq;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 rsp_valid_int;
  logic                 rsp_fire;

  // Acceptance depends only on registered credit state and reset.
  assign bus.req_ready = reset_n && (out_cnt < DEPTH_CNT);
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign ld_fire       = req_fire && (bus.req_st == REQ_LOAD);
  assign st_fire       = req_fire && (bus.req_st == REQ_STORE);
  assign in_range      = 32'(bus.req_addr) < 32'(SIZE);

  // One narrow RAM per byte lane; each lane has its own write enable and read register.
  for (genvar i = 0; i < NB_COL; i++) begin : g_lane
    logic [COL_WIDTH-1:0] ram [SIZE];
    logic [COL_WIDTH-1:0] rd_q;

    // Lane write for in-range stores with this lane enabled.
    always_ff @(posedge clk) begin
      if (st_fire && in_range && bus.req_we[i])
        ram[bus.req_addr] <= bus.req_wdata[i*COL_WIDTH +: COL_WIDTH];
    end

    // Synchronous lane read into S1; out-of-range loads read as zero.
    always_ff @(posedge clk) begin
      if (!reset_n)     rd_q <= '0;
      else if (ld_fire) rd_q <= in_range ? ram[bus.req_addr] : '0;
    end

    assign s1_data[i*COL_WIDTH +: COL_WIDTH] = rd_q;
  end

  // S1 control: valid for exactly the cycle after a load is accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= ld_fire;
      if (ld_fire) begin
        s1_tag <= bus.req_tag;
        s1_err <= !in_range;
      end
    end
  end

  assign s1_entry   = '{data: s1_data, tag: s1_tag, err: s1_err};
  assign head_entry = rsp_entry_t'(fifo_head);

  // S1 bypasses the FIFO only when nothing older is queued and the consumer is ready.
  assign rsp_valid_int = s1_valid || !fifo_empty;
  assign rsp_fire      = rsp_valid_int && bus.rsp_ready;
  assign fifo_deq      = !fifo_empty && bus.rsp_ready;
  assign fifo_enq      = s1_valid && !(fifo_empty && bus.rsp_ready);

  dmem_rsp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq      (fifo_enq),
    .enq_data (s1_entry),
    .deq      (fifo_deq),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Outstanding-load credit counter.
  always_ff @(posedge clk) begin
    if (!reset_n)                 out_cnt <= '0;
    else if (ld_fire && !rsp_fire) out_cnt <= out_cnt + 1'b1;
    else if (!ld_fire && rsp_fire) out_cnt <= out_cnt - 1'b1;
  end

  // Response source select: oldest queued entry first, otherwise S1.
  always_comb begin
    // NOTE: default assignment first so no path leaves out_entry unassigned (no latch).
    out_entry = s1_entry;
    if (!fifo_empty) out_entry = head_entry;
  end

  assign bus.rsp_valid = reset_n && rsp_valid_int;
  assign bus.rsp_rdata = reset_n ? out_entry.data : '0;
  assign bus.rsp_tag   = reset_n ? out_entry.tag  : '0;
  assign bus.rsp_err   = reset_n && out_entry.err;

  // A full FIFO plus a valid S1 would exceed the credit bound.
  a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n) !(fifo_full && s1_valid));

endmodule

// File: doc/dmem_ext_pipe.md
Name: dmem_ext_pipe

Overview:
Parametrised, single-port, byte-lane-writable data memory with a valid/ready request channel and a registered, in-order load-response channel. It replaces the combinational-read data memory used in the core's memory stage. It adds a synchronous read, response backpressure with credit-limited acceptance, tagged responses and out-of-range detection, so the core can stall on memory rather than assume zero-cycle reads.

Parameters:
SIZE, 1024, number of words; must be at most 2**ADDR_WIDTH.
ADDR_WIDTH, 10, word-address width.
COL_WIDTH, 8, bits per byte lane.
NB_COL, 4, lanes per word; word width W = NB_COL*COL_WIDTH.
TAG_WIDTH, 4, width of the opaque request tag returned with each load response.
RSP_DEPTH, 2, maximum number of outstanding loads and depth of the response FIFO; must be at least 1.

Ports:
clk  in  1  clock; all state updates on its rising edge.
reset_n  in  1  synchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid && req_ready.
req_st  in  1  1 = store, 0 = load.
req_we  in  NB_COL  per-lane write enable; stores only.
req_addr  in  ADDR_WIDTH  word address.
req_wdata  in  W  store data.
req_tag  in  TAG_WIDTH  tag echoed on the load response.
rsp_valid  out  1  load response present.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  W  load data.
rsp_tag  out  TAG_WIDTH  tag of the load that produced this response.
rsp_err  out  1  load address was >= SIZE.

Behaviour:
- Reset: clk is the only clock; reset_n is synchronous and active-low. While reset_n = 0: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_tag = 0, rsp_err = 0. The outstanding counter, the S1 stage and the FIFO are cleared. RAM contents are not reset.
- Reset mid-operation: all in-flight loads are dropped with no response. Stores already accepted have committed. req_ready rises in the first cycle after reset_n returns to 1.
- Outstanding counter OUT, range 0..RSP_DEPTH:
  - +1 on load acceptance.
  - -1 on a response handshake (rsp_valid && rsp_ready).
  - Both in the same cycle leave OUT unchanged.
- req_ready = reset_n && (OUT < RSP_DEPTH), decoded from registered state only. It never depends combinationally on req_valid, req_st or rsp_ready. Stores are also gated by req_ready.
- Store accepted in cycle N:
  - At edge N, for each lane i with req_we[i] = 1, RAM[addr] lane i <= req_wdata lane i.
  - No response is produced.
  - If addr >= SIZE, the store is silently dropped.
- Load accepted in cycle N:
  - The RAM is read synchronously at edge N into stage S1, which holds {valid, data, tag, err}.
  - If addr >= SIZE: data = 0 and err = 1.
- Read-after-write: a load accepted in the cycle after a store to the same address returns the new data. Only one request per cycle is possible, so the memory is single-port with no same-cycle conflict.
- Response path:
  - S1 enqueues into the response FIFO, dmem_rsp_fifo, which is first-word-fall-through and depth RSP_DEPTH.
  - rsp_* are driven by the FIFO head when the FIFO is non-empty; otherwise by S1.
  - Response order equals load-acceptance order.
  - When the FIFO is empty and rsp_ready = 1, S1 is consumed directly and not enqueued.
- Latency:
  - Minimum 1 cycle: load accepted at N gives rsp_valid in N+1.
  - Sustained throughput is 1 load per cycle while rsp_ready = 1.
- rsp_valid/rsp_rdata/rsp_tag/rsp_err stay stable while rsp_valid && !rsp_ready.
- FIFO overflow is impossible because OUT <= RSP_DEPTH. An assertion is required: enqueue while full, or dequeue while empty, is a bug.
- Outputs when rsp_valid = 0: rsp_rdata/rsp_tag/rsp_err hold their last values.

Decomposition:
- Package dmem_pkg:
  - Parameter-derived constants: W, counter width $clog2(RSP_DEPTH+1).
  - A typedef struct for the response entry {data, tag, err}.
  - A localparam for the load/store encoding of req_st.
- Sub-module dmem_rsp_fifo: parametrised by entry type width and DEPTH.
  - Ports: clk, reset_n, enq, enq_data, deq, head, empty, full.
  - Circular buffer with wrap-around read/write pointers plus an occupancy count.
- Top level holds the RAM array with a per-lane generate write, S1, OUT and the output mux.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles with req_valid = 1 -> req_ready = 0, rsp_valid = 0 throughout, and no RAM write occurs.
- Byte lanes: preload addr 5 = 0x11223344; store we = 4'b0101, wdata = 0xAABBCCDD; next-cycle load tag 3 -> rsp_rdata = 0x11BB33DD, rsp_tag = 3, 1-cycle latency.
- Streaming: 8 back-to-back loads of addrs 0..7 with rsp_ready = 1 -> 8 consecutive rsp_valid cycles in order, tags 0..7.
- Backpressure: hold rsp_ready = 0, issue loads -> exactly RSP_DEPTH = 2 accepted, then req_ready = 0. Raise rsp_ready -> responses return in order and req_ready reasserts the next cycle.
- Out of range: with SIZE = 1000, load addr 1010 -> rsp_err = 1, rsp_rdata = 0. Store to 1010 -> no RAM change, verified by reading addrs 0..999 unchanged.
- Reset mid-flight: 2 loads outstanding, pulse reset_n low for 1 cycle -> no stale rsp_valid afterwards and OUT = 0 (req_ready = 1 next cycle).
